serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 119 +++++++++++
 tb/tb_serial_adder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice walks the operands LSB first over WIDTH cycles.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVERFLOW_EN.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             start,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             carryIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic             carryOut
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             fa_sum, fa_carry;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  // Full-adder slice fed by the operand LSBs and the running carry.
  always_comb begin
    fa_sum   = a_q[0] ^ b_q[0] ^ carry_q;
    fa_carry = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = opA;
          b_d     = opB;
          carry_d = carryIn;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        res_d   = {fa_sum, res_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_carry;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == LastBit) begin
          cout_d  = fa_carry;
`ifdef SERIAL_ADDER_OVERFLOW_EN
          // carry_q here is the carry into the MSB position
          ovf_d   = carry_q ^ fa_carry;
`endif
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    busy     = (state_q == StRun);
    done     = (state_q == StDone);
    sum      = res_q;
    carryOut = cout_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    overflow = ovf_q;
`endif
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder: WIDTH=8 vectors plus an exhaustive WIDTH=2 sweep.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start8 = 1'b0, ci8 = 1'b0;
  logic [7:0] opa8 = '0, opb8 = '0;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;
  logic       start2 = 1'b0, ci2 = 1'b0;
  logic [1:0] opa2 = '0, opb2 = '0;
  logic       busy2, done2, cout2, ovf2;
  logic [1:0] sum2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk      (clk),
    .rstN     (rst_n),
    .start    (start8),
    .opA      (opa8),
    .opB      (opb8),
    .carryIn  (ci8),
    .busy     (busy8),
    .done     (done8),
    .sum      (sum8),
`ifdef SERIAL_ADDER_OVERFLOW_EN
    .overflow (ovf8),
`endif
    .carryOut (cout8)
  );

  serial_adder #(.WIDTH(2)) u_dut2 (
    .clk      (clk),
    .rstN     (rst_n),
    .start    (start2),
    .opA      (opa2),
    .opB      (opb2),
    .carryIn  (ci2),
    .busy     (busy2),
    .done     (done2),
    .sum      (sum2),
`ifdef SERIAL_ADDER_OVERFLOW_EN
    .overflow (ovf2),
`endif
    .carryOut (cout2)
  );

`ifndef SERIAL_ADDER_OVERFLOW_EN
  assign ovf8 = 1'b0;
  assign ovf2 = 1'b0;
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full addition on the WIDTH=8 instance; operands are scrambled right after acceptance.
  task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                      output logic [7:0] s, output logic co, output logic ov, output int bcyc);
    int n;
    @(negedge clk);
    opa8 = a; opb8 = b; ci8 = ci; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; opa8 = ~a; opb8 = ~b; ci8 = ~ci;
    bcyc = 0;
    n = 0;
    while (done8 !== 1'b1 && n < 30) begin
      if (busy8) bcyc++;
      @(negedge clk);
      n++;
    end
    check_eq("done_seen", 32'(done8), 32'd1);
    check_eq("busy_and_done", 32'(busy8), 32'd0);
    s  = sum8;
    co = cout8;
    ov = ovf8;
    @(negedge clk);
    check_eq("done_one_cycle", 32'(done8), 32'd0);
  endtask

  initial begin
    logic [7:0] s;
    logic       co, ov;
    int         bc, dcnt;
    logic [7:0] va [0:31];
    logic [7:0] vb [0:31];
    logic       vc [0:31];
    logic [8:0] exp9;
    logic [2:0] exp3;
    logic [1:0] s2;
    logic       co2, ov2, exp_ov2;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 32'(busy8), 32'd0);
    check_eq("rst_done", 32'(done8), 32'd0);
    check_eq("rst_sum", 32'(sum8), 32'd0);
    check_eq("rst_cout", 32'(cout8), 32'd0);
    rst_n = 1'b1;

    add8(8'h5A, 8'h3C, 1'b0, s, co, ov, bc);
    check_eq("5a_3c_busy_cycles", 32'(bc), 32'd8);
    check_eq("5a_3c_sum", 32'(s), 32'h96);
    check_eq("5a_3c_cout", 32'(co), 32'd0);
    check_eq("5a_3c_sum_held", 32'(sum8), 32'h96);

    add8(8'hFF, 8'h01, 1'b0, s, co, ov, bc);
    check_eq("ff_01_sum", 32'(s), 32'h00);
    check_eq("ff_01_cout", 32'(co), 32'd1);

    add8(8'hFF, 8'hFF, 1'b1, s, co, ov, bc);
    check_eq("ff_ff_c1_sum", 32'(s), 32'hFF);
    check_eq("ff_ff_c1_cout", 32'(co), 32'd1);

`ifdef SERIAL_ADDER_OVERFLOW_EN
    add8(8'h7F, 8'h01, 1'b0, s, co, ov, bc);
    check_eq("7f_01_sum", 32'(s), 32'h80);
    check_eq("7f_01_ovf", 32'(ov), 32'd1);
    check_eq("7f_01_cout", 32'(co), 32'd0);
    add8(8'h80, 8'h80, 1'b0, s, co, ov, bc);
    check_eq("80_80_sum", 32'(s), 32'h00);
    check_eq("80_80_ovf", 32'(ov), 32'd1);
    check_eq("80_80_cout", 32'(co), 32'd1);
    add8(8'h10, 8'h20, 1'b0, s, co, ov, bc);
    check_eq("10_20_sum", 32'(s), 32'h30);
    check_eq("10_20_ovf", 32'(ov), 32'd0);
`endif

    // start held high with operands changing every cycle: accepts at cycles 0, 10, 20
    dcnt = 0;
    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      if (done8) begin
        dcnt++;
        check_eq("held_done_phase", 32'(i % 10), 32'd9);
        if (i >= 9) begin
          exp9 = 9'(va[i-9]) + 9'(vb[i-9]) + 9'(vc[i-9]);
          check_eq("held_sum", 32'(sum8), 32'(exp9[7:0]));
          check_eq("held_cout", 32'(cout8), 32'(exp9[8]));
        end
      end
      if (i < 32) begin
        va[i] = 8'(i * 13 + 5);
        vb[i] = 8'(i * 7 + 200);
        vc[i] = 1'(i);
        opa8 = va[i]; opb8 = vb[i]; ci8 = vc[i];
      end
      start8 = 1'b1;
    end
    start8 = 1'b0;
    check_eq("held_done_count", 32'(dcnt), 32'd3);
    repeat (12) @(negedge clk);

    // Reset during the 4th RUN cycle discards the operation
    @(negedge clk);
    opa8 = 8'h5A; opb8 = 8'h3C; ci8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("midrst_busy", 32'(busy8), 32'd0);
    check_eq("midrst_done", 32'(done8), 32'd0);
    check_eq("midrst_sum", 32'(sum8), 32'd0);
    check_eq("midrst_cout", 32'(cout8), 32'd0);
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done8 || busy8) dcnt++;
    end
    check_eq("midrst_no_done", 32'(dcnt), 32'd0);
    add8(8'h01, 8'h01, 1'b0, s, co, ov, bc);
    check_eq("post_rst_sum", 32'(s), 32'h02);
    check_eq("post_rst_cout", 32'(co), 32'd0);

    // Exhaustive WIDTH=2 sweep
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        for (int c = 0; c < 2; c++) begin
          @(negedge clk);
          opa2 = 2'(a); opb2 = 2'(b); ci2 = 1'(c); start2 = 1'b1;
          @(negedge clk);
          start2 = 1'b0;
          dcnt = 0;
          s2 = '0; co2 = 1'b0; ov2 = 1'b0;
          for (int k = 0; k < 6; k++) begin
            if (done2) begin
              dcnt++;
              s2 = sum2; co2 = cout2; ov2 = ovf2;
            end
            @(negedge clk);
          end
          exp3 = 3'(a) + 3'(b) + 3'(c);
          check_eq("w2_done_once", 32'(dcnt), 32'd1);
          check_eq("w2_result", 32'({co2, s2}), 32'(exp3));
`ifdef SERIAL_ADDER_OVERFLOW_EN
          exp_ov2 = (a[1] == b[1]) && (exp3[1] != a[1]);
          check_eq("w2_ovf", 32'(ov2), 32'(exp_ov2));
`else
          exp_ov2 = 1'b0;
          if (exp_ov2 != ov2) check_eq("w2_ovf_absent", 32'(ov2), 32'(exp_ov2));
`endif
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
